uart_link_partner: RTL and testbench

- Parametrised UART endpoint with one transmitter, one receiver and a receive FIFO.
- It is the next generation of the comm-partner UART used at the LM32 system level. It generalises data width, oversampling and receive buffering, and adds error reporting.
- The same RTL serves as a synthesizable peer on the `uart_rxd`/`uart_txd` pair of `system`, and as a streaming UART front-end inside SoC peripherals.

---
 rtl/uart_link_partner_if.sv | 31 +++
 rtl/uart_link_partner.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_link_partner.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_link_partner_if.sv
// uart_link_partner_if: word handshake and status signals between uart_link_partner (slave) and its client (master).
// Carries rx_parity_err only when UART_LINK_PARTNER_PARITY_EN is defined.
interface uart_link_partner_if #(
   parameter int data_bits = 8
);
   logic [data_bits-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [data_bits-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_overrun;
`ifdef UART_LINK_PARTNER_PARITY_EN
   logic                 rx_parity_err;
`endif
   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
`ifdef UART_LINK_PARTNER_PARITY_EN
      , input rx_parity_err
`endif
   );
   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
`ifdef UART_LINK_PARTNER_PARITY_EN
      , output rx_parity_err
`endif
   );
endinterface

// File: rtl/uart_link_partner.sv
// uart_link_partner: UART endpoint with 16x oversampled TX/RX FSMs and an RX FIFO.
// Define UART_LINK_PARTNER_PARITY_EN to add a parity bit (parameter parity_odd, output rx_parity_err).
module uart_link_partner #(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200,
   parameter int data_bits      = 8,
   parameter int rx_fifo_depth  = 4
`ifdef UART_LINK_PARTNER_PARITY_EN
   ,
   parameter bit parity_odd     = 1'b0
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               uart_rxd,
   output logic               uart_txd,
   uart_link_partner_if.slave bus
);
   localparam int div_raw = clk_freq / (16 * uart_baud_rate);
   localparam int divisor = div_raw < 1 ? 1 : div_raw;
   localparam int cw = divisor > 1 ? $clog2(divisor) : 1;
   localparam int aw = $clog2(rx_fifo_depth);
   localparam logic [3:0] last_bit = 4'(data_bits - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_LINK_PARTNER_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

`ifdef UART_LINK_PARTNER_PARITY_EN
   localparam state_t s_after_data = S_PARITY;
`else
   localparam state_t s_after_data = S_STOP;
`endif

   logic [cw-1:0] div_cnt_q, div_cnt_d;
   logic          tick;

   state_t                tx_state_q, tx_state_d;
   logic [3:0]            tx_phase_q, tx_phase_d;
   logic [3:0]            tx_bit_q, tx_bit_d;
   logic [data_bits-1:0]  tx_shift_q, tx_shift_d;
   logic                  tx_ready_q, tx_ready_d;

   logic [1:0]            rx_sync_q, rx_sync_d;
   logic                  rx_prev_q, rx_prev_d;
   logic                  rx_s, rx_mid, rx_end;
   state_t                rx_state_q, rx_state_d;
   logic [3:0]            rx_phase_q, rx_phase_d;
   logic [3:0]            rx_bit_q, rx_bit_d;
   logic [data_bits-1:0]  rx_shift_q, rx_shift_d;
   logic                  push_q, push_d;
   logic                  ferr_q, ferr_d;

`ifdef UART_LINK_PARTNER_PARITY_EN
   logic                  tx_par_q, tx_par_d;
   logic                  rx_par_bad_q, rx_par_bad_d;
   logic                  perr_q, perr_d;
`endif

   logic [data_bits-1:0]  mem_q [rx_fifo_depth];
   logic [aw:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic                  full, pop, wr_en;
   logic                  ovr_q, ovr_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [data_bits-1:0]  rx_data_q, rx_data_d;

   always_comb begin
      tick = div_cnt_q == cw'(divisor - 1);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_phase_d = tx_phase_q;
      tx_bit_d = tx_bit_q;
      tx_shift_d = tx_shift_q;
`ifdef UART_LINK_PARTNER_PARITY_EN
      tx_par_d = tx_par_q;
`endif
      if (tx_state_q == S_IDLE) begin
         if (bus.tx_valid && tx_ready_q) begin
            tx_state_d = S_START;
            tx_phase_d = '0;
            tx_bit_d = '0;
            tx_shift_d = bus.tx_data;
`ifdef UART_LINK_PARTNER_PARITY_EN
            tx_par_d = (^bus.tx_data) ^ parity_odd;
`endif
         end
      end else if (tick) begin
         tx_phase_d = tx_phase_q + 4'd1;
         if (tx_phase_q == 4'd15) begin
            case (tx_state_q)
               S_START: tx_state_d = S_DATA;
               S_DATA: begin
                  tx_shift_d = tx_shift_q >> 1;
                  tx_bit_d = tx_bit_q + 4'd1;
                  tx_state_d = tx_bit_q == last_bit ? s_after_data : S_DATA;
               end
`ifdef UART_LINK_PARTNER_PARITY_EN
               S_PARITY: tx_state_d = S_STOP;
`endif
               default: tx_state_d = S_IDLE;
            endcase
         end
      end
      tx_ready_d = tx_state_d == S_IDLE;
   end

   always_comb begin
      case (tx_state_q)
         S_START: uart_txd = 1'b0;
         S_DATA: uart_txd = tx_shift_q[0];
`ifdef UART_LINK_PARTNER_PARITY_EN
         S_PARITY: uart_txd = tx_par_q;
`endif
         default: uart_txd = 1'b1;
      endcase
   end

   // Every RX decision uses the synchronised line; sampling is at mid-bit (phase 7).
   always_comb begin
      rx_sync_d = {rx_sync_q[0], uart_rxd};
      rx_s = rx_sync_q[1];
      rx_prev_d = rx_s;
      rx_mid = tick && rx_phase_q == 4'd7;
      rx_end = tick && rx_phase_q == 4'd15;
      rx_state_d = rx_state_q;
      rx_phase_d = (rx_state_q != S_IDLE && tick) ? rx_phase_q + 4'd1 : rx_phase_q;
      rx_bit_d = rx_bit_q;
      rx_shift_d = rx_shift_q;
      push_d = 1'b0;
      ferr_d = 1'b0;
`ifdef UART_LINK_PARTNER_PARITY_EN
      rx_par_bad_d = rx_par_bad_q;
      perr_d = 1'b0;
`endif
      case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               rx_state_d = S_START;
               rx_phase_d = '0;
               rx_bit_d = '0;
            end
         end
         S_START: rx_state_d = (rx_mid && rx_s) ? S_IDLE : rx_end ? S_DATA : S_START;
         S_DATA: begin
            if (rx_mid) rx_shift_d = {rx_s, rx_shift_q[data_bits-1:1]};
            if (rx_end) begin
               rx_bit_d = rx_bit_q + 4'd1;
               rx_state_d = rx_bit_q == last_bit ? s_after_data : S_DATA;
            end
         end
`ifdef UART_LINK_PARTNER_PARITY_EN
         S_PARITY: begin
            if (rx_mid) rx_par_bad_d = rx_s ^ (^rx_shift_q) ^ parity_odd;
            if (rx_end) rx_state_d = S_STOP;
         end
`endif
         default: begin
            if (rx_mid) begin
               rx_state_d = S_IDLE;
               ferr_d = !rx_s;
`ifdef UART_LINK_PARTNER_PARITY_EN
               perr_d = rx_s && rx_par_bad_q;
               push_d = rx_s && !rx_par_bad_q;
`else
               push_d = rx_s;
`endif
            end
         end
      endcase
   end

   // Head is registered; a word written into the slot becoming head bypasses the memory.
   always_comb begin
      full = wptr_q[aw] != rptr_q[aw] && wptr_q[aw-1:0] == rptr_q[aw-1:0];
      pop = rx_valid_q && bus.rx_ready;
      wr_en = push_q && (!full || pop);
      ovr_d = push_q && full && !pop;
      wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
      rx_valid_d = wptr_d != rptr_d;
      rx_data_d = !rx_valid_d ? rx_data_q
                : (wr_en && rptr_d[aw-1:0] == wptr_q[aw-1:0]) ? rx_shift_q
                : mem_q[rptr_d[aw-1:0]];
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[aw-1:0]] <= rx_shift_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt_q <= '0;
         tx_state_q <= S_IDLE;
         tx_phase_q <= '0;
         tx_bit_q <= '0;
         tx_shift_q <= '0;
         tx_ready_q <= 1'b0;
         rx_sync_q <= 2'b11;
         rx_prev_q <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_phase_q <= '0;
         rx_bit_q <= '0;
         rx_shift_q <= '0;
         push_q <= 1'b0;
         ferr_q <= 1'b0;
         wptr_q <= '0;
         rptr_q <= '0;
         ovr_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q <= '0;
`ifdef UART_LINK_PARTNER_PARITY_EN
         tx_par_q <= 1'b0;
         rx_par_bad_q <= 1'b0;
         perr_q <= 1'b0;
`endif
      end else begin
         div_cnt_q <= div_cnt_d;
         tx_state_q <= tx_state_d;
         tx_phase_q <= tx_phase_d;
         tx_bit_q <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_ready_q <= tx_ready_d;
         rx_sync_q <= rx_sync_d;
         rx_prev_q <= rx_prev_d;
         rx_state_q <= rx_state_d;
         rx_phase_q <= rx_phase_d;
         rx_bit_q <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         push_q <= push_d;
         ferr_q <= ferr_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovr_q <= ovr_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q <= rx_data_d;
`ifdef UART_LINK_PARTNER_PARITY_EN
         tx_par_q <= tx_par_d;
         rx_par_bad_q <= rx_par_bad_d;
         perr_q <= perr_d;
`endif
      end
   end

   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_frame_err = ferr_q;
   assign bus.rx_overrun = ovr_q;
`ifdef UART_LINK_PARTNER_PARITY_EN
   assign bus.rx_parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_link_partner.sv
// tb_uart_link_partner: self-checking bench for uart_link_partner at 16 clocks per bit.
// Covers reset, TX waveform, loopback, bench-driven RX frames, glitch, overrun and (with UART_LINK_PARTNER_PARITY_EN) parity.
module tb_uart_link_partner;
`ifdef UART_LINK_PARTNER_PARITY_EN
   localparam int frame_bits = 11;
`else
   localparam int frame_bits = 10;
`endif

   logic clk = 1'b0;
   logic rst;
   logic loop;
   logic drv_rxd;
   logic uart_rxd;
   logic uart_txd;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ferr_cnt = 0;
   int   ovr_cnt = 0;
   int   perr_cnt = 0;
   logic [7:0] exp_q [$];

   uart_link_partner_if #(.data_bits(8)) bus ();

   uart_link_partner #(
      .clk_freq(16000000),
      .uart_baud_rate(1000000),
      .data_bits(8),
      .rx_fifo_depth(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .uart_rxd(uart_rxd),
      .uart_txd(uart_txd),
      .bus(bus)
   );

   assign uart_rxd = loop ? uart_txd : drv_rxd;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every word the DUT hands out must match the oldest expected word.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (bus.rx_frame_err) ferr_cnt++;
         if (bus.rx_overrun) ovr_cnt++;
`ifdef UART_LINK_PARTNER_PARITY_EN
         if (bus.rx_parity_err) perr_cnt++;
`endif
         if (bus.rx_valid && bus.rx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rx_pop: got unexpected word %0h, expected none", bus.rx_data);
            end else begin
               check("rx_data", bus.rx_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_tx_ready();
      for (int i = 0; i < 1000 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
      check("tx_ready_wait", bus.tx_ready, 1'b1);
   endtask

   task automatic tx_send(input logic [7:0] w);
      wait_tx_ready();
      bus.tx_data = w;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic tx_wave(input logic [7:0] w);
      logic [10:0] exp_bits;
      logic [1:0]  got;
      logic        seen;
`ifdef UART_LINK_PARTNER_PARITY_EN
      exp_bits = {1'b1, ^w, w, 1'b0};
`else
      exp_bits = {1'b1, 1'b1, w, 1'b0};
`endif
      tx_send(w);
      for (int s = 0; s < frame_bits; s++) begin
         seen = 1'b0;
         got = {1'b0, exp_bits[s]};
         for (int c = 0; c < 16; c++) begin
            if (!seen && {bus.tx_ready, uart_txd} !== {1'b0, exp_bits[s]}) begin
               seen = 1'b1;
               got = {bus.tx_ready, uart_txd};
            end
            @(negedge clk);
         end
         check($sformatf("tx_%02h_slot%0d {ready,txd}", w, s), 32'(got), {30'd0, 1'b0, exp_bits[s]});
      end
      check($sformatf("tx_%02h_ready_back", w), bus.tx_ready, 1'b1);
      check($sformatf("tx_%02h_idle_line", w), uart_txd, 1'b1);
   endtask

   task automatic rx_frame(input logic [8:0] d, input int nb, input logic stop);
      drv_rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         drv_rxd = d[i];
         repeat (16) @(negedge clk);
      end
      drv_rxd = stop;
      repeat (16) @(negedge clk);
      drv_rxd = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] exp;
   } lb_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_word;
      int         exp_ferr;
   } rx_vec_t;

   lb_vec_t    lb_tab [7];
   rx_vec_t    rx_tab [5];
   logic [7:0] ovr_words [5];
   int         ovr_exp [5];

   initial begin
      int f0, o0, p0;
      lb_tab[0] = '{8'h00, 8'h00};
      lb_tab[1] = '{8'hFF, 8'hFF};
      lb_tab[2] = '{8'h3C, 8'h3C};
      lb_tab[3] = '{8'hA5, 8'hA5};
      lb_tab[4] = '{8'h5A, 8'h5A};
      lb_tab[5] = '{8'h01, 8'h01};
      lb_tab[6] = '{8'h80, 8'h80};
      rx_tab[0] = '{8'h5A, 1'b1, 1'b1, 0};
      rx_tab[1] = '{8'h5A, 1'b0, 1'b0, 1};
      rx_tab[2] = '{8'hC3, 1'b1, 1'b1, 0};
      rx_tab[3] = '{8'h00, 1'b0, 1'b0, 1};
      rx_tab[4] = '{8'hFF, 1'b1, 1'b1, 0};
      ovr_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      ovr_exp = '{0, 0, 0, 0, 1};

      rst = 1'b0;
      loop = 1'b0;
      drv_rxd = 1'b1;
      bus.tx_valid = 1'b1;
      bus.tx_data = 8'h55;
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset%0d_txd", i), uart_txd, 1'b1);
         check($sformatf("reset%0d_tx_ready", i), bus.tx_ready, 1'b0);
         check($sformatf("reset%0d_rx_valid", i), bus.rx_valid, 1'b0);
      end
      check("reset_rx_data", bus.rx_data, 8'h00);
      check("reset_errs", {bus.rx_frame_err, bus.rx_overrun}, 2'b00);
      rst = 1'b1;
      bus.tx_valid = 1'b0;
      @(negedge clk);
      check("reset_release_tx_ready", bus.tx_ready, 1'b1);

      tx_wave(8'hA5);

      loop = 1'b1;
      f0 = ferr_cnt;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(lb_tab[i].exp);
         tx_send(lb_tab[i].tx);
      end
      drain("loopback_drain");
      check("loopback_no_ferr", ferr_cnt - f0, 0);
      check("loopback_no_ovr", ovr_cnt, 0);
      loop = 1'b0;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         f0 = ferr_cnt;
         if (rx_tab[i].exp_word) exp_q.push_back(rx_tab[i].data);
`ifdef UART_LINK_PARTNER_PARITY_EN
         rx_frame({^rx_tab[i].data, rx_tab[i].data}, 9, rx_tab[i].stop);
`else
         rx_frame({1'b0, rx_tab[i].data}, 8, rx_tab[i].stop);
`endif
         check($sformatf("rx_vec%0d_ferr", i), ferr_cnt - f0, rx_tab[i].exp_ferr);
         check($sformatf("rx_vec%0d_rx_valid", i), bus.rx_valid, 1'b0);
      end
      drain("rx_vec_drain");

      f0 = ferr_cnt;
      drv_rxd = 1'b0;
      repeat (4) @(negedge clk);
      drv_rxd = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_ferr", ferr_cnt - f0, 0);
      check("glitch_rx_valid", bus.rx_valid, 1'b0);

      loop = 1'b1;
      bus.rx_ready = 1'b0;
      o0 = ovr_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(ovr_words[i]);
         tx_send(ovr_words[i]);
         wait_tx_ready();
         repeat (20) @(negedge clk);
         check($sformatf("ovr_word%0d_count", i), ovr_cnt - o0, ovr_exp[i]);
      end
      check("ovr_head_valid", bus.rx_valid, 1'b1);
      check("ovr_head_data", bus.rx_data, 8'h11);
      bus.rx_ready = 1'b1;
      drain("ovr_drain");
      repeat (4) @(negedge clk);
      check("ovr_empty_after", bus.rx_valid, 1'b0);
      loop = 1'b0;

`ifdef UART_LINK_PARTNER_PARITY_EN
      tx_wave(8'h07);
      f0 = ferr_cnt;
      p0 = perr_cnt;
      rx_frame({1'b0, 8'h07}, 9, 1'b1);
      check("par_bad_perr", perr_cnt - p0, 1);
      check("par_bad_ferr", ferr_cnt - f0, 0);
      check("par_bad_rx_valid", bus.rx_valid, 1'b0);
      p0 = perr_cnt;
      exp_q.push_back(8'h07);
      rx_frame({1'b1, 8'h07}, 9, 1'b1);
      check("par_good_perr", perr_cnt - p0, 0);
      drain("par_drain");
`else
      p0 = perr_cnt;
      check("no_parity_errs", p0, 0);
`endif

      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
